// File: rtl/piso_shift_register_pkg.sv
// Shared types and defaults for the PISO transmitter slice.
package piso_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;

endpackage

// File: rtl/piso_shift_register_if.sv
// Word-in / bit-out bus of the PISO transmitter.
// master: the word producer and serial consumer; slave: the transmitter.
interface piso_shift_register_if #(
    parameter int WIDTH = piso_pkg::DEFAULT_WIDTH
);

    logic             load;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             last;

    modport master (
        output load,
        output din,
        input  ready,
        input  sout,
        input  sout_valid,
        input  last
    );

    modport slave (
        input  load,
        input  din,
        output ready,
        output sout,
        output sout_valid,
        output last
    );

endinterface

// File: rtl/piso_shift_register_bit_counter.sv
// Bit position counter for one frame: counts 0..WIDTH-1 and flags the final data bit.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     at_last
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    // Clear has priority so a reload on the final bit restarts at 0.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_last = (cnt == LAST);

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out transmitter, MSB first, one bit per clock,
// back-to-back frames with no gap.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit
// after the data bits (frame length WIDTH+1, last/ready move to that bit).
module piso_shift_register
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    piso_shift_register_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt_unused;
    logic             at_last;
    logic             ready;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_inc;
`ifdef PISO_PARITY_EN
    logic             par;
`endif

    // Bit count is kept for debug visibility; frame control only needs at_last.
    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .cnt     (bit_cnt_unused),
        .at_last (at_last)
    );

    // Handshake, serial outputs, counter control and next state.
    always_comb begin
        state_nxt      = state;
        bus.sout       = 1'b0;
        bus.sout_valid = 1'b0;
        bus.last       = 1'b0;
        ready          = 1'b0;
        cnt_inc        = 1'b0;
        cnt_clr        = 1'b0;

        case (state)
            IDLE: begin
                ready = 1'b1;
            end
            SHIFT: begin
                bus.sout       = shreg[WIDTH-1];
                bus.sout_valid = 1'b1;
`ifndef PISO_PARITY_EN
                bus.last       = at_last;
                ready          = at_last;
`endif
                cnt_inc        = !at_last;
                cnt_clr        = at_last;
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                bus.sout       = par;
                bus.sout_valid = 1'b1;
                bus.last       = 1'b1;
                ready          = 1'b1;
            end
`endif
            default: ;
        endcase

        // Reset blocks new words combinationally.
        ready     = ready && !rst;
        bus.ready = ready;
        accept    = bus.load && ready;
        cnt_clr   = cnt_clr || accept;

        case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (at_last) begin
`ifdef PISO_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_nxt = accept ? SHIFT : IDLE;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register and shift register; an accept always reloads, otherwise shift while in SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                shreg <= bus.din;
            end else if (state == SHIFT) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end
        end
    end

`ifdef PISO_PARITY_EN
    // Even parity of the accepted word, captured together with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= ^bus.din;
        end
    end
`endif

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register (WIDTH=16), valid with PISO_PARITY_EN defined or not.
module tb_piso_shift_register;
    import piso_pkg::*;

    localparam int W = 16;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    piso_shift_register_if #(.WIDTH(W)) bus ();

    piso_shift_register #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;
    bit q[$];
    logic [W-1:0] rx = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: queue of bits still to appear on sout for the current frame.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            armed = 1'b1;
        end else begin
            bit acc;
            acc = bus.load && (q.size() <= 1);
            if (q.size() > 0) void'(q.pop_front());
            if (acc) begin
                for (int i = W - 1; i >= 0; i--) q.push_back(bus.din[i]);
`ifdef PISO_PARITY_EN
                q.push_back(^bus.din);
`endif
            end
        end
    end

    // Receiver on the same clock: shifts in every valid bit.
    always @(posedge clk) begin
        if (bus.sout_valid) rx <= {rx[W-2:0], bus.sout};
    end

    // Every-cycle comparison against the reference queue.
    always @(negedge clk) begin
        if (armed) begin
            bit ev, es, el, er;
            ev = (q.size() > 0);
            es = ev ? q[0] : 1'b0;
            el = (q.size() == 1);
            er = !rst && (q.size() <= 1);
            check("sout",       64'(bus.sout),       64'(es));
            check("sout_valid", 64'(bus.sout_valid), 64'(ev));
            check("last",       64'(bus.last),       64'(el));
            check("ready",      64'(bus.ready),      64'(er));
        end
    end

    task automatic send(input logic [W-1:0] w);
        bus.load = 1'b1;
        bus.din  = w;
        step();
        bus.load = 1'b0;
        bus.din  = W'($urandom);
    endtask

    task automatic capture(input int n, input int inject_at, input logic [W-1:0] inject_w,
                           output logic [63:0] bits, output logic [63:0] lastmask,
                           output int nbits, output int rdy_cnt);
        bits = '0; lastmask = '0; nbits = 0; rdy_cnt = 0;
        for (int i = 1; i <= n; i++) begin
            if (bus.sout_valid) begin
                bits = {bits[62:0], bus.sout};
                nbits++;
            end
            lastmask = {lastmask[62:0], bus.last};
            if (bus.ready) rdy_cnt++;
            if (i == inject_at) begin
                bus.load = 1'b1;
                bus.din  = inject_w;
            end else begin
                bus.load = 1'b0;
            end
            step();
        end
        bus.load = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, "_ready"}, 64'(bus.ready),      64'd1);
        check({name, "_valid"}, 64'(bus.sout_valid), 64'd0);
        check({name, "_sout"},  64'(bus.sout),       64'd0);
    endtask

    initial begin
        logic [63:0] bits, lmask;
        int nb, rc;
        bus.load = 1'b0;
        bus.din  = '0;
        rst      = 1'b1;
        step();
        check("ready_in_rst", 64'(bus.ready), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check_idle("after_rst");
        check("after_rst_last", 64'(bus.last), 64'd0);

        // 1. single word
        send(16'hA5C3);
        capture(FL, 0, '0, bits, lmask, nb, rc);
`ifdef PISO_PARITY_EN
        check("t1_bits", bits, 64'h14B86);
`else
        check("t1_bits", bits, 64'hA5C3);
`endif
        check("t1_nbits", 64'(nb), 64'(FL));
        check("t1_last", lmask, 64'd1);
        check("t1_ready_cnt", 64'(rc), 64'd1);
        check_idle("t1_end");

        // 2. back-to-back, second word loaded on the final bit of the first
        send(16'hFFFF);
        capture(2 * FL, FL, 16'h0001, bits, lmask, nb, rc);
`ifdef PISO_PARITY_EN
        check("t2_bits", bits, 64'h3_FFFC_0003);
`else
        check("t2_bits", bits, 64'hFFFF_0001);
`endif
        check("t2_nbits", 64'(nb), 64'(2 * FL));
        check("t2_last", lmask, (64'd1 << FL) | 64'd1);
        check("t2_ready_cnt", 64'(rc), 64'd2);
        check_idle("t2_end");

        // 3. load while busy is ignored
        send(16'h8000);
        capture(FL, 5, 16'h1234, bits, lmask, nb, rc);
`ifdef PISO_PARITY_EN
        check("t3_bits", bits, 64'h10001);
`else
        check("t3_bits", bits, 64'h8000);
`endif
        check("t3_last", lmask, 64'd1);
        check_idle("t3_end");

        // 4. reset in cycle 7 of a frame
        send(16'hA5C3);
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_idle("t4_abort");
        check("t4_abort_last", 64'(bus.last), 64'd0);
        send(16'h00FF);
        capture(FL, 0, '0, bits, lmask, nb, rc);
`ifdef PISO_PARITY_EN
        check("t4_bits", bits, 64'h1FE);
`else
        check("t4_bits", bits, 64'h00FF);
`endif
        check("t4_nbits", 64'(nb), 64'(FL));

        // 5. loopback into the receiver
        send(16'hBEEF);
        repeat (W) step();
        check("t5_loopback", 64'(rx), 64'hBEEF);
        repeat (2) step();

`ifdef PISO_PARITY_EN
        // 6. parity bit values and last placement
        send(16'h0001);
        capture(FL, 0, '0, bits, lmask, nb, rc);
        check("t6a_bits", bits, 64'h3);
        check("t6a_last", lmask, 64'd1);
        send(16'h0003);
        capture(FL, 0, '0, bits, lmask, nb, rc);
        check("t6b_bits", bits, 64'h6);
`endif

        // random traffic, checked by the every-cycle compare
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 59) == 0);
            bus.load = ($urandom_range(0, 2) != 0);
            bus.din  = W'($urandom);
            step();
        end
        rst      = 1'b0;
        bus.load = 1'b0;
        repeat (FL + 2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
